// File: rtl/rd_active_vertex_offset_lane_v2.sv
// Per-core active-vertex buffer: FIFOs routed vertex IDs, derives offset/delta BRAM
// read addresses, and defers the iteration-end marker until the buffer has drained.
module rd_active_vertex_offset_lane_v2 #(
  parameter int V_ID_WIDTH        = 32,
  parameter int ITERATION_WIDTH   = 32,
  parameter int V_OFF_AWIDTH      = 14,
  parameter int DELTA_BRAM_AWIDTH = 14,
  parameter int CORE_NUM_WIDTH    = 4,
  parameter int CORE_ID           = 0,
  parameter int FIFO_DEPTH        = 16,
  parameter int PROG_FULL_THRESH  = 12,
  parameter int CNT_W             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [V_ID_WIDTH-1:0]        front_active_v_id,
  input  logic                         front_active_v_valid,
  input  logic                         front_iteration_end,
  input  logic                         front_iteration_end_valid,
  input  logic [ITERATION_WIDTH-1:0]   front_iteration_id,
  input  logic                         next_stage_full,
  output logic                         stage_full,
  output logic [V_ID_WIDTH-1:0]        active_v_id,
  output logic                         active_v_id_valid,
  output logic [V_OFF_AWIDTH-1:0]      rd_active_v_offset_addr,
  output logic [DELTA_BRAM_AWIDTH-1:0] rd_active_v_value_addr,
  output logic                         rd_active_v_addr_valid,
  output logic                         iteration_end,
  output logic                         iteration_end_valid,
  output logic [ITERATION_WIDTH-1:0]   iteration_id,
  output logic [CNT_W-1:0]             occupancy,
  output logic                         overflow_err,
  output logic                         misroute_err,
  output logic                         end_overrun_err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                       state, state_nxt;
  logic [ITERATION_WIDTH-1:0]   pend_id, pend_nxt;
  logic [V_ID_WIDTH-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [V_ID_WIDTH-1:0]        id_shift;
  logic route_ok, full, pop, wr, end_in, emit, overrun;

  assign route_ok = front_active_v_id[CORE_NUM_WIDTH-1:0] == CORE_NUM_WIDTH'(CORE_ID);
  assign full     = occupancy == CNT_W'(FIFO_DEPTH);
  assign pop      = !next_stage_full && (occupancy != '0);
  // A full FIFO still takes a write when a slot frees up in the same cycle.
  assign wr       = front_active_v_valid && route_ok && (!full || pop);
  assign end_in   = front_iteration_end && front_iteration_end_valid;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_id;
    emit      = 1'b0;
    overrun   = 1'b0;
    case (state)
      IDLE: if (end_in) begin
        state_nxt = PENDING;
        pend_nxt  = front_iteration_id;
      end
      PENDING: begin
        // Only release once nothing of this iteration is buffered or in flight.
        emit = (occupancy == '0) && !pop && !wr;
        if (end_in) begin
          pend_nxt = front_iteration_id;
          overrun  = !emit;
        end else if (emit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= front_active_v_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      pend_id           <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      occupancy         <= '0;
      stage_full        <= 1'b0;
      active_v_id       <= '0;
      active_v_id_valid <= 1'b0;
      iteration_end     <= 1'b0;
      iteration_id      <= '0;
      overflow_err      <= 1'b0;
      misroute_err      <= 1'b0;
      end_overrun_err   <= 1'b0;
    end else begin
      state             <= state_nxt;
      pend_id           <= pend_nxt;
      stage_full        <= occupancy >= CNT_W'(PROG_FULL_THRESH);
      active_v_id_valid <= pop;
      iteration_end     <= emit;
      if (emit) iteration_id <= pend_id;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        active_v_id <= mem[rd_ptr];
      end
      case ({wr, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (front_active_v_valid && !route_ok) misroute_err <= 1'b1;
      if (front_active_v_valid && route_ok && full && !pop) overflow_err <= 1'b1;
      if (overrun) end_overrun_err <= 1'b1;
    end
  end

  assign id_shift                = active_v_id >> CORE_NUM_WIDTH;
  assign rd_active_v_offset_addr = id_shift[V_OFF_AWIDTH-1:0];
  assign rd_active_v_value_addr  = id_shift[DELTA_BRAM_AWIDTH-1:0];
  assign rd_active_v_addr_valid  = active_v_id_valid;
  assign iteration_end_valid     = iteration_end;
endmodule

// File: tb/tb_rd_active_vertex_offset_lane_v2.sv
// Directed bench for rd_active_vertex_offset_lane_v2 (default parameters, CORE_ID 0).
module tb_rd_active_vertex_offset_lane_v2;
  logic        clk = 0, rst = 1;
  logic [31:0] v_id = 0;
  logic        v_valid = 0, f_end = 0, f_end_v = 0, nsf = 0;
  logic [31:0] f_iter = 0;
  logic        stage_full, a_valid, addr_valid, it_end, it_end_v;
  logic [31:0] a_id, it_id;
  logic [13:0] off_addr, val_addr;
  logic [4:0]  occ;
  logic        ovf, mis, ovr;

  rd_active_vertex_offset_lane_v2 dut (
    .clk(clk), .rst(rst),
    .front_active_v_id(v_id), .front_active_v_valid(v_valid),
    .front_iteration_end(f_end), .front_iteration_end_valid(f_end_v),
    .front_iteration_id(f_iter), .next_stage_full(nsf),
    .stage_full(stage_full), .active_v_id(a_id), .active_v_id_valid(a_valid),
    .rd_active_v_offset_addr(off_addr), .rd_active_v_value_addr(val_addr),
    .rd_active_v_addr_valid(addr_valid), .iteration_end(it_end),
    .iteration_end_valid(it_end_v), .iteration_id(it_id), .occupancy(occ),
    .overflow_err(ovf), .misroute_err(mis), .end_overrun_err(ovr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [31:0] id; logic wv; logic ns;
    logic ev; logic [31:0] eid; logic [4:0] eocc; logic emis;
  } vec_t;
  vec_t tbl [11];

  // Monitor state
  int cyc, vcnt, pcnt, last_v_cyc, pulse_cyc;
  logic [31:0] pulse_id;
  logic [31:0] got [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; v_valid = 0; f_end = 0; f_end_v = 0; nsf = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic mon_clear();
    vcnt = 0; pcnt = 0; last_v_cyc = -1; pulse_cyc = -1; pulse_id = '0;
    got.delete();
  endtask

  task automatic monitor(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (a_valid) begin vcnt++; last_v_cyc = cyc; got.push_back(a_id); end
      if (it_end) begin pcnt++; pulse_cyc = cyc; pulse_id = it_id; end
    end
  endtask

  task automatic wr_one(input logic [31:0] id);
    v_id = id; v_valid = 1; step(); v_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0;
    // id, wv, ns, exp_valid, exp_id, exp_occ, exp_misroute
    tbl[0]  = '{32'h20, 1, 0, 0, 32'h00, 5'd1, 0};
    tbl[1]  = '{32'h00, 0, 0, 1, 32'h20, 5'd0, 0};
    tbl[2]  = '{32'h00, 0, 0, 0, 32'h20, 5'd0, 0};
    tbl[3]  = '{32'h31, 1, 0, 0, 32'h20, 5'd0, 1};
    tbl[4]  = '{32'h00, 0, 0, 0, 32'h20, 5'd0, 1};
    tbl[5]  = '{32'h40, 1, 1, 0, 32'h20, 5'd1, 1};
    tbl[6]  = '{32'h50, 1, 1, 0, 32'h20, 5'd2, 1};
    tbl[7]  = '{32'h00, 0, 0, 1, 32'h40, 5'd1, 1};
    tbl[8]  = '{32'h60, 1, 0, 1, 32'h50, 5'd1, 1};
    tbl[9]  = '{32'h00, 0, 0, 1, 32'h60, 5'd0, 1};
    tbl[10] = '{32'h00, 0, 0, 0, 32'h60, 5'd0, 1};

    // Reset state
    do_reset();
    chk("rst_occ", occ, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_id", a_id, 0);
    chk("rst_sfull", stage_full, 0);
    chk("rst_end", it_end, 0);
    chk("rst_errs", {ovf, mis, ovr}, 0);

    // Table: latency-2 path, misroute drop, backpressure and simultaneous push/pop
    for (int i = 0; i < 11; i++) begin
      v_id = tbl[i].id; v_valid = tbl[i].wv; nsf = tbl[i].ns;
      step();
      chk($sformatf("v%0d_valid", i), a_valid, tbl[i].ev);
      chk($sformatf("v%0d_addrv", i), addr_valid, tbl[i].ev);
      chk($sformatf("v%0d_id", i), a_id, tbl[i].eid);
      chk($sformatf("v%0d_off", i), off_addr, 14'(tbl[i].eid >> 4));
      chk($sformatf("v%0d_val", i), val_addr, 14'(tbl[i].eid >> 4));
      chk($sformatf("v%0d_occ", i), occ, tbl[i].eocc);
      chk($sformatf("v%0d_mis", i), mis, tbl[i].emis);
    end
    v_valid = 0;
    chk("no_ovf_yet", ovf, 0);

    // Fill to full, stage_full lag, overflow drop, ordered drain
    do_reset();
    nsf = 1;
    for (int i = 1; i <= 13; i++) begin
      wr_one(32'(i) << 4);
      chk($sformatf("fill%0d_occ", i), occ, 5'(i));
      if (i == 12) chk("sfull_lag", stage_full, 0);
      if (i == 13) chk("sfull_rise", stage_full, 1);
    end
    for (int i = 14; i <= 16; i++) wr_one(32'(i) << 4);
    chk("full_occ", occ, 16);
    chk("full_no_ovf", ovf, 0);
    wr_one(32'h110);
    chk("ovf_occ", occ, 16);
    chk("ovf_err", ovf, 1);
    nsf = 0;
    mon_clear();
    monitor(20);
    chk("drain_cnt", vcnt, 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("drain%0d", i), got[i], 32'(i + 1) << 4);
    chk("drain_occ", occ, 0);
    chk("drain_sfull", stage_full, 0);

    // End held behind buffered IDs
    do_reset();
    nsf = 1;
    wr_one(32'h100); wr_one(32'h110); wr_one(32'h120);
    f_iter = 7; f_end = 1; f_end_v = 1; step(); f_end = 0; f_end_v = 0;
    mon_clear();
    monitor(10);
    chk("hold_no_pulse", pcnt, 0);
    chk("hold_no_valid", vcnt, 0);
    nsf = 0;
    mon_clear();
    monitor(12);
    chk("end_vcnt", vcnt, 3);
    chk("end_pcnt", pcnt, 1);
    chk("end_id", pulse_id, 7);
    chk("end_after_last", pulse_cyc > last_v_cyc, 1);
    chk("end_order", got.size() == 3 ? {got[0], got[1], got[2]} : 96'h0,
        {32'h100, 32'h110, 32'h120});

    // End on empty FIFO
    do_reset();
    mon_clear();
    f_iter = 5; f_end = 1; f_end_v = 1; step(); f_end = 0; f_end_v = 0;
    monitor(1);
    chk("empty_end_pulse", it_end, 1);
    chk("empty_end_v", it_end_v, 1);
    chk("empty_end_id", it_id, 5);
    monitor(4);
    chk("empty_end_once", pcnt, 1);
    chk("empty_no_ovr", ovr, 0);

    // Two ends while non-empty: overrun, only the second emitted
    nsf = 1;
    wr_one(32'h200);
    f_iter = 8; f_end = 1; f_end_v = 1; step(); f_end = 0; f_end_v = 0;
    step(); step();
    f_iter = 9; f_end = 1; f_end_v = 1; step(); f_end = 0; f_end_v = 0;
    chk("ovr_err", ovr, 1);
    nsf = 0;
    mon_clear();
    monitor(10);
    chk("ovr_pcnt", pcnt, 1);
    chk("ovr_id", pulse_id, 9);

    // Asynchronous reset mid-operation
    do_reset();
    wr_one(32'h70); step();
    chk("pre_rst_id", a_id, 32'h70);
    nsf = 1;
    for (int i = 0; i < 5; i++) wr_one(32'h80 + (32'(i) << 4));
    f_iter = 3; f_end = 1; f_end_v = 1; step(); f_end = 0; f_end_v = 0;
    chk("pre_rst_occ", occ, 5);
    #2 rst = 1;
    #1;
    chk("arst_occ", occ, 0);
    chk("arst_id", a_id, 0);
    chk("arst_sfull", stage_full, 0);
    chk("arst_valid", a_valid, 0);
    @(posedge clk); #1 rst = 0; nsf = 0;
    mon_clear();
    monitor(10);
    chk("post_rst_valid", vcnt, 0);
    chk("post_rst_pulse", pcnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rd_active_vertex_offset_lane_v2.md
Name: rd_active_vertex_offset_lane_v2

Overview:
Per-core active-vertex stage with a parametrised depth. It buffers incoming active vertex IDs in an internal FIFO, checks that each ID belongs to this core, and derives the offset-BRAM and delta-BRAM read addresses. Unlike the previous generation, it holds an iteration-end marker until every buffered vertex has left, so no end is ever lost. It sits between the active-vertex scheduler and the offset/value BRAM read stage; the CORE_NUM wrapper instantiates one per core.

Parameters:
V_ID_WIDTH, 32, vertex ID width
ITERATION_WIDTH, 32, iteration counter width
V_OFF_AWIDTH, 14, offset BRAM address width
DELTA_BRAM_AWIDTH, 14, delta BRAM address width
CORE_NUM_WIDTH, 4, log2 of core count; also the interleave shift
CORE_ID, 0, this lane's core index (compared to ID low bits)
FIFO_DEPTH, 16, buffer entries, power of 2, at least 4
PROG_FULL_THRESH, 12, occupancy at which stage_full asserts; 1 to FIFO_DEPTH-1
CNT_W, $clog2(FIFO_DEPTH)+1, occupancy width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
front_active_v_id  in  V_ID_WIDTH  incoming vertex ID
front_active_v_valid  in  1  write strobe
front_iteration_end  in  1  end-of-iteration flag
front_iteration_end_valid  in  1  qualifies front_iteration_end
front_iteration_id  in  ITERATION_WIDTH  iteration number, sampled with the end flag
next_stage_full  in  1  backpressure from downstream
stage_full  out  1  registered almost-full to upstream
active_v_id  out  V_ID_WIDTH  registered output ID
active_v_id_valid  out  1  output strobe
rd_active_v_offset_addr  out  V_OFF_AWIDTH  offset BRAM address
rd_active_v_value_addr  out  DELTA_BRAM_AWIDTH  delta BRAM address
rd_active_v_addr_valid  out  1  equals active_v_id_valid
iteration_end  out  1  end pulse
iteration_end_valid  out  1  end qualifier, same as iteration_end
iteration_id  out  ITERATION_WIDTH  id of the emitted end
occupancy  out  CNT_W  FIFO entry count
overflow_err  out  1  sticky: write while FIFO full
misroute_err  out  1  sticky: ID low bits differ from CORE_ID
end_overrun_err  out  1  sticky: new end while one is pending

Behaviour:
- Reset (async assert, released on a clk edge): pointers, occupancy, pending flag, all sticky errors and every output register go to 0.
- Write path:
  - A write is accepted when front_active_v_valid=1, ID[CORE_NUM_WIDTH-1:0]==CORE_ID and occupancy<FIFO_DEPTH.
  - A mis-routed ID is dropped and sets misroute_err.
  - A write at occupancy==FIFO_DEPTH is dropped and sets overflow_err, unless a pop happens in the same cycle; in that case the write is accepted.
- Read path:
  - pop = !next_stage_full && occupancy!=0.
  - The popped entry appears on active_v_id with active_v_id_valid=1 on the next cycle (latency 1).
  - active_v_id holds its last value when valid=0.
- Minimum write-to-output latency is 2 cycles, with an empty FIFO and no backpressure.
- Occupancy: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop. Pointers wrap modulo FIFO_DEPTH.
- stage_full is registered: stage_full(t+1) = (occupancy(t) >= PROG_FULL_THRESH). The one-cycle lag is covered by the FIFO_DEPTH-PROG_FULL_THRESH headroom.
- Addresses are combinational from the registered ID: (active_v_id >> CORE_NUM_WIDTH), truncated to V_OFF_AWIDTH and DELTA_BRAM_AWIDTH respectively.
- End handling (states IDLE and PENDING):
  - IDLE: end && end_valid sets pend_id=front_iteration_id and moves to PENDING. A write in the same cycle is enqueued ahead of the end.
  - PENDING: emit when occupancy==0, no pop this cycle and no accepted write this cycle. Emission registers iteration_end=iteration_end_valid=1 for exactly 1 cycle with iteration_id=pend_id, then returns to IDLE.
  - The end pulse is never in the same cycle as, or earlier than, the last active_v_id_valid of that iteration.
  - A new end in the emission cycle is latched; state stays PENDING with the new id.
  - A new end in PENDING in any other cycle overwrites pend_id and sets end_overrun_err.
- Reset mid-operation discards buffered IDs and any pending end; no end pulse is produced.

Test Plan:
1. Reset, then write ID 0x20 (CORE_ID 0) -> after 2 cycles active_v_id=0x20, valid=1, offset_addr=0x2, value_addr=0x2; occupancy back to 0.
2. 13 writes with next_stage_full=1 -> occupancy 13; stage_full rises the cycle after occupancy reaches 12. 3 more writes reach occupancy 16. A 17th write is dropped and overflow_err=1. Release backpressure -> 16 IDs output in order.
3. Write ID 0x31 with CORE_ID=0 -> dropped, misroute_err=1, occupancy stays 0, no output.
4. Write 3 IDs, then end with iteration_id=7 while next_stage_full=1 for 10 cycles -> no end pulse. After release, three valid outputs, then a 1-cycle iteration_end=1 with iteration_id=7 no earlier than the cycle after the last valid.
5. End id 5 on an empty FIFO -> pulse 1 cycle later with id 5. Two ends 3 cycles apart with the FIFO held non-empty -> end_overrun_err=1 and only the second id is emitted.
6. Assert rst asynchronously with 5 entries and an end pending -> all outputs 0 immediately, occupancy 0, and no end pulse after release.
